// File: rtl/pmod_i2c_arbiter.sv
// pmod_i2c_arbiter: shares one bit-level I2C command engine between NREQ
// requesters. A grant covers a whole START..STOP transaction. A stalled or
// vanished requester is recovered by a forced STOP.
//
// Build option: define PMOD_I2C_ARB_PRIORITY_EN to make IDLE arbitration
// fixed priority (lowest index wins) instead of round-robin.
module pmod_i2c_arbiter #(
    parameter int NREQ           = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_i,
    output logic [NREQ-1:0]     gnt_o,
    input  logic [2*NREQ-1:0]   cmd_i,
    input  logic [NREQ-1:0]     stb_i,
    input  logic [8*NREQ-1:0]   data_i,
    input  logic [NREQ-1:0]     ack_i,
    output logic [NREQ-1:0]     ready_o,
    output logic [7:0]          rdata_o,
    output logic                rack_o,
    output logic                err_o,
    output logic [1:0]          m_cmd,
    output logic                m_stb,
    output logic [7:0]          m_data,
    output logic                m_ack,
    input  logic                m_ready,
    input  logic [7:0]          m_rdata,
    input  logic                m_rack,
    input  logic                m_err,
    output logic                busy_o,
    output logic                timeout_o
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]    CMD_STOP = 2'b01;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_RELEASE,
        S_ABORT
    } state_t;

    // Command as presented to the engine.
    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ack;
    } fwd_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   wdog_q, wdog_d;
    fwd_t            fwd_q, fwd_d;
    logic            m_stb_q, m_stb_d;
    logic            timeout_q, timeout_d;
    logic            to_cause_q, to_cause_d;
    logic            rel_low_q, rel_low_d;

    logic [1:0]      cmd_a  [NREQ];
    logic [7:0]      data_a [NREQ];
    logic [IW-1:0]   rr_start;
    logic [IW-1:0]   win;
    logic [IW-1:0]   owner_nxt;
    logic            accept;

    // Unpack the flat per-requester buses so the owner can index them.
    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign cmd_a[g]  = cmd_i[2*g +: 2];
        assign data_a[g] = data_i[8*g +: 8];
    end

`ifdef PMOD_I2C_ARB_PRIORITY_EN
    assign rr_start = '0;
`else
    assign rr_start = ptr_q;
`endif

    // First requesting index at or after start, wrapping around.
    function automatic logic [IW-1:0] pick(input logic [NREQ-1:0] req,
                                           input logic [IW-1:0]   start);
        logic [IW-1:0] idx;
        logic [IW-1:0] j;
        logic          found;
        idx   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = IW'((int'(start) + k) % NREQ);
            if (!found && req[j]) begin
                found = 1'b1;
                idx   = j;
            end
        end
        return idx;
    endfunction

    assign win       = pick(req_i, rr_start);
    assign owner_nxt = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);

    // Only the owner sees ready, and only while no forwarded strobe is in flight.
    assign ready_o = (state_q == S_ACTIVE && m_ready && !m_stb_q) ? gnt_q : '0;
    assign accept  = stb_i[owner_q] & ready_o[owner_q];

    // Next-state, grant, watchdog and forwarding decisions.
    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        wdog_d     = wdog_q;
        fwd_d      = fwd_q;
        m_stb_d    = 1'b0;
        timeout_d  = 1'b0;
        to_cause_d = to_cause_q;
        rel_low_d  = rel_low_q;
        case (state_q)
            S_IDLE: begin
                if (m_ready && |req_i) begin
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    owner_d    = win;
                    wdog_d     = '0;
                    state_d    = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept) begin
                    fwd_d.cmd  = cmd_a[owner_q];
                    fwd_d.data = data_a[owner_q];
                    fwd_d.ack  = ack_i[owner_q];
                    m_stb_d    = 1'b1;
                    wdog_d     = '0;
                    if (cmd_a[owner_q] == CMD_STOP) begin
                        state_d   = S_RELEASE;
                        rel_low_d = 1'b0;
                    end else if (!req_i[owner_q]) begin
                        state_d    = S_ABORT;
                        gnt_d      = '0;
                        to_cause_d = 1'b0;
                    end
                end else if (!req_i[owner_q]) begin
                    state_d    = S_ABORT;
                    gnt_d      = '0;
                    to_cause_d = 1'b0;
                end else if (m_ready) begin
                    if (wdog_q == WD_LAST) begin
                        state_d    = S_ABORT;
                        gnt_d      = '0;
                        to_cause_d = 1'b1;
                    end else begin
                        wdog_d = wdog_q + 1'b1;
                    end
                end
            end
            S_ABORT: begin
                // Wait out any strobe still in flight before the forced STOP.
                if (m_ready && !m_stb_q) begin
                    fwd_d.cmd = CMD_STOP;
                    m_stb_d   = 1'b1;
                    timeout_d = to_cause_q;
                    rel_low_d = 1'b0;
                    state_d   = S_RELEASE;
                end
            end
            S_RELEASE: begin
                // STOP done once the engine has gone busy and come back.
                if (!m_ready) begin
                    rel_low_d = 1'b1;
                end else if (rel_low_q) begin
                    gnt_d   = '0;
                    ptr_d   = owner_nxt;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset drops any transaction without a STOP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            ptr_q      <= '0;
            wdog_q     <= '0;
            fwd_q      <= '{cmd: 2'b00, data: 8'h00, ack: 1'b1};
            m_stb_q    <= 1'b0;
            timeout_q  <= 1'b0;
            to_cause_q <= 1'b0;
            rel_low_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            wdog_q     <= wdog_d;
            fwd_q      <= fwd_d;
            m_stb_q    <= m_stb_d;
            timeout_q  <= timeout_d;
            to_cause_q <= to_cause_d;
            rel_low_q  <= rel_low_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign m_cmd     = fwd_q.cmd;
    assign m_data    = fwd_q.data;
    assign m_ack     = fwd_q.ack;
    assign m_stb     = m_stb_q;
    assign timeout_o = timeout_q;
    assign busy_o    = (state_q != S_IDLE);
    assign rdata_o   = m_rdata;
    assign rack_o    = m_rack;
    assign err_o     = m_err;

endmodule

// File: tb/tb_pmod_i2c_arbiter.sv
// Bench for pmod_i2c_arbiter: table-driven response pass-through checks,
// a scoreboard of expected engine strobes, and hand sequences for the
// multi-cycle arbitration, abort, timeout and reset cases.
module tb_pmod_i2c_arbiter;
    localparam int NREQ = 2;
    localparam int TO   = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [NREQ-1:0]  req_i, gnt_o, stb_i, ack_i, ready_o;
    logic [2*NREQ-1:0] cmd_i;
    logic [8*NREQ-1:0] data_i;
    logic [7:0]       rdata_o, m_data, m_rdata;
    logic             rack_o, err_o, m_stb, m_ack, m_ready, m_rack, m_err;
    logic [1:0]       m_cmd;
    logic             busy_o, timeout_o;

    pmod_i2c_arbiter #(.NREQ(NREQ), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .gnt_o(gnt_o), .cmd_i(cmd_i),
        .stb_i(stb_i), .data_i(data_i), .ack_i(ack_i), .ready_o(ready_o),
        .rdata_o(rdata_o), .rack_o(rack_o), .err_o(err_o), .m_cmd(m_cmd),
        .m_stb(m_stb), .m_data(m_data), .m_ack(m_ack), .m_ready(m_ready),
        .m_rdata(m_rdata), .m_rack(m_rack), .m_err(m_err), .busy_o(busy_o),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Engine model: busy for three cycles after each strobe.
    logic [1:0] eng_cnt;
    always @(posedge clk or posedge rst) begin
        if (rst)             eng_cnt <= 2'd0;
        else if (m_stb)      eng_cnt <= 2'd3;
        else if (eng_cnt != 0) eng_cnt <= eng_cnt - 2'd1;
    end
    assign m_ready = (eng_cnt == 2'd0);

    typedef struct {
        logic [1:0] cmd;
        logic [7:0] data;
        logic       ack;
        bit         chk_data;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;

    int checks = 0, errors = 0;
    int mon_checks = 0, mon_errors = 0;
    int stb_cnt = 0, to_cnt = 0;

    // Scoreboard: every engine strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (m_stb) begin
            stb_cnt++;
            mon_checks++;
            if (exp_q.size() == 0) begin
                mon_errors++;
                $display("FAIL unexpected_stb got cmd=%b data=%h", m_cmd, m_data);
            end else begin
                e = exp_q.pop_front();
                if (m_cmd !== e.cmd || (e.chk_data && (m_data !== e.data || m_ack !== e.ack))) begin
                    mon_errors++;
                    $display("FAIL stb_fwd got cmd=%b data=%h ack=%b want cmd=%b data=%h ack=%b",
                             m_cmd, m_data, m_ack, e.cmd, e.data, e.ack);
                end
            end
        end
        if (timeout_o) to_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_gnt", gnt_o, 0);
        chk("rst_m_stb", m_stb, 0);
        chk("rst_m_cmd", m_cmd, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_ack", m_ack, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_timeout", timeout_o, 0);
        chk("rst_ready", ready_o, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_i = '0; stb_i = '0; cmd_i = '0; data_i = '0; ack_i = '1;
        exp_q.delete();
        tick(); tick();
        rst = 1'b0;
        tick();
    endtask

    // Wait for requester r to be ready, strobe one command, record expectation.
    task automatic send(input int r, input logic [1:0] c, input logic [7:0] d, input logic a);
        int n = 0;
        while (!ready_o[r] && n < 100) begin tick(); n++; end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL ready_wait r=%0d got 0 want 1", r);
        end else begin
            cmd_i[2*r +: 2] = c;
            data_i[8*r +: 8] = d;
            ack_i[r] = a;
            stb_i[r] = 1'b1;
            exp_q.push_back('{cmd: c, data: d, ack: a, chk_data: (c == 2'b10 || c == 2'b11)});
            tick();
            stb_i[r] = 1'b0;
        end
    endtask

    task automatic wait_gnt(input string name, input logic [NREQ-1:0] g);
        int n = 0;
        while (gnt_o !== g && n < 100) begin tick(); n++; end
        chk(name, gnt_o, g);
    endtask

    typedef struct {
        logic [7:0] rdata;
        logic       rack;
        logic       err;
        logic [7:0] exp_rdata;
        logic       exp_rack;
        logic       exp_err;
    } pt_vec_t;
    pt_vec_t pt_tab [4];

    int n, s0, t0;

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "bench did not finish");
    end

    initial begin
        pt_tab[0] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        pt_tab[1] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0};
        pt_tab[2] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1};
        pt_tab[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
        m_rdata = '0; m_rack = 1'b0; m_err = 1'b0;

        rst = 1'b1;
        req_i = '0; stb_i = '0; cmd_i = '0; data_i = '0; ack_i = '1;
        #2;
        chk_reset_vals();
        do_reset();

        // Single requester 0: START, WRITE 30, WRITE 02, READ (nack), STOP.
        req_i = 2'b01;
        tick();
        chk("t1_gnt_one_cycle", gnt_o, 2'b01);
        chk("t1_busy", busy_o, 1);
        for (int i = 0; i < 4; i++) begin
            m_rdata = pt_tab[i].rdata; m_rack = pt_tab[i].rack; m_err = pt_tab[i].err;
            #1;
            chk("pt_rdata", rdata_o, pt_tab[i].exp_rdata);
            chk("pt_rack", rack_o, pt_tab[i].exp_rack);
            chk("pt_err", err_o, pt_tab[i].exp_err);
            tick();
            chk("pt_gnt_hold", gnt_o, 2'b01);
        end
        m_err = 1'b0;
        s0 = stb_cnt;
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b10, 8'h30, 1'b1);
        send(0, 2'b10, 8'h02, 1'b1);
        send(0, 2'b11, 8'h00, 1'b0);
        send(0, 2'b01, 8'h00, 1'b1);
        req_i = 2'b00;
        wait_gnt("t1_gnt_release", 2'b00);
        chk("t1_idle", busy_o, 0);
        tick(); tick();
        chk("t1_stb_count", stb_cnt - s0, 5);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Two requesters together; foreign strobes ignored; grant order.
        do_reset();
        req_i = 2'b11;
        tick();
        chk("t2_first_gnt", gnt_o, 2'b01);
        s0 = stb_cnt;
        cmd_i[3:2] = 2'b10; data_i[15:8] = 8'hA4; stb_i[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t3_ready1_low", ready_o[1], 0);
            tick();
        end
        stb_i[1] = 1'b0;
        tick();
        chk("t3_no_stb", stb_cnt - s0, 0);
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b01, 8'h00, 1'b1);
        req_i[0] = 1'b0;
        wait_gnt("t2_release0", 2'b00);
        chk("t2_idle_gap", busy_o, 0);
        tick();
        chk("t2_second_gnt", gnt_o, 2'b10);
        req_i[0] = 1'b1;
        send(1, 2'b00, 8'h00, 1'b1);
        send(1, 2'b01, 8'h00, 1'b1);
        wait_gnt("t2_release1", 2'b00);
        tick();
        chk("t2_third_gnt", gnt_o, 2'b01);
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b01, 8'h00, 1'b1);
        wait_gnt("t2_release2", 2'b00);
        tick();
`ifdef PMOD_I2C_ARB_PRIORITY_EN
        chk("t2_fourth_gnt_prio", gnt_o, 2'b01);
`else
        chk("t2_fourth_gnt_rr", gnt_o, 2'b10);
`endif

        // Watchdog: START then silence.
        do_reset();
        req_i = 2'b01;
        tick();
        send(0, 2'b00, 8'h00, 1'b1);
        t0 = to_cnt;
        exp_q.push_back('{cmd: 2'b01, data: 8'h00, ack: 1'b1, chk_data: 1'b0});
        n = 0;
        while (!timeout_o && n < 60) begin tick(); n++; end
        req_i = 2'b00;
        chk("t4_timeout_seen", timeout_o, 1);
        chk("t4_forced_stop", m_stb, 1);
        chk("t4_forced_cmd", m_cmd, 2'b01);
        chk("t4_gnt_clear", gnt_o, 0);
        chk("t4_wait_min", (n >= TO) ? 1 : 0, 1);
        chk("t4_wait_max", (n <= TO + 8) ? 1 : 0, 1);
        tick(); tick(); tick();
        chk("t4_one_pulse", to_cnt - t0, 1);
        n = 0;
        while (busy_o && n < 50) begin tick(); n++; end
        chk("t4_back_idle", busy_o, 0);
        chk("t4_queue_empty", exp_q.size(), 0);

        // Owner drops req after a WRITE.
        do_reset();
        req_i = 2'b11;
        tick();
        chk("t5_gnt0", gnt_o, 2'b01);
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b10, 8'h55, 1'b1);
        n = 0;
        while (!ready_o[0] && n < 50) begin tick(); n++; end
        t0 = to_cnt;
        exp_q.push_back('{cmd: 2'b01, data: 8'h00, ack: 1'b1, chk_data: 1'b0});
        req_i[0] = 1'b0;
        tick();
        chk("t5_gnt_clear", gnt_o, 0);
        chk("t5_busy", busy_o, 1);
        wait_gnt("t5_next_gnt", 2'b10);
        chk("t5_no_timeout", to_cnt - t0, 0);
        chk("t5_queue_empty", exp_q.size(), 0);

        // Reset mid-WRITE after one completed transaction by requester 0.
        do_reset();
        req_i = 2'b01;
        tick();
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b01, 8'h00, 1'b1);
        req_i = 2'b00;
        wait_gnt("t6_release", 2'b00);
        req_i = 2'b01;
        tick();
        chk("t6_regrant", gnt_o, 2'b01);
        send(0, 2'b00, 8'h00, 1'b1);
        send(0, 2'b10, 8'h77, 1'b0);
        chk("t6_mid_write", m_stb, 1);
        #2;
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk_reset_vals();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_i = 2'b11;
        tick();
        chk("t6_post_reset_gnt", gnt_o, 2'b01);

        checks += mon_checks;
        errors += mon_errors;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
